// File: rtl/mp_adder4.sv
// mp_adder4: registered WIDTH-bit add/subtract built from 64-bit carry-select blocks.
// The top result bit is the carry-out when adding and the borrow/sign when subtracting.
module mp_adder4 #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result
);

  localparam int RW   = WIDTH + 1;
  localparam int BLK  = 64;
  localparam int NBLK = (RW + BLK - 1) / BLK;

  logic [RW-1:0]   op_a;
  logic [RW-1:0]   op_b;
  logic [RW-1:0]   sum_next;
  logic [NBLK-1:0] blk_cin;

  // b is zero-extended before inversion so bit WIDTH of a + ~b + 1 is the borrow.
  assign op_a       = {1'b0, in_a};
  assign op_b       = subtract ? ~{1'b0, in_b} : {1'b0, in_b};
  assign blk_cin[0] = subtract;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    localparam int LO = g * BLK;
    localparam int BW = ((RW - LO) > BLK) ? BLK : (RW - LO);

    if (g < NBLK - 1) begin : g_mid
      logic [BW:0] sum_c0;
      logic [BW:0] sum_c1;

      assign sum_c0 = {1'b0, op_a[LO +: BW]} + {1'b0, op_b[LO +: BW]};
      assign sum_c1 = {1'b0, op_a[LO +: BW]} + {1'b0, op_b[LO +: BW]} + {{BW{1'b0}}, 1'b1};

      assign sum_next[LO +: BW] = blk_cin[g] ? sum_c1[BW-1:0] : sum_c0[BW-1:0];
      assign blk_cin[g+1]       = blk_cin[g] ? sum_c1[BW]     : sum_c0[BW];
    end else begin : g_last
      // The final block's carry-out falls off the WIDTH+1 result, so it is not formed.
      logic [BW-1:0] sum_c0;
      logic [BW-1:0] sum_c1;

      assign sum_c0 = op_a[LO +: BW] + op_b[LO +: BW];
      assign sum_c1 = op_a[LO +: BW] + op_b[LO +: BW] + {{(BW-1){1'b0}}, 1'b1};

      assign sum_next[LO +: BW] = blk_cin[g] ? sum_c1 : sum_c0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result <= '0;
    end else begin
      result <= sum_next;
    end
  end

endmodule

// File: tb/tb_mp_adder4.sv
// tb_mp_adder4: directed and random checks of mp_adder4 against hand-computed
// constants and a plain integer add/subtract reference.
module tb_mp_adder4;

  localparam int W = 1027;

  logic         clk;
  logic         resetn;
  logic         subtract;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W:0]   result;

  int checks;
  int failures;

  mp_adder4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
    logic [W:0] ae;
    logic [W:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    return sub ? (ae - be) : (ae + be);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [1055:0] v;
    for (int w = 0; w < 33; w++) v[w*32 +: 32] = $urandom;
    return v[W-1:0];
  endfunction

  function automatic logic [W:0] pow2(input int k);
    logic [W:0] one;
    one = 1;
    return one << k;
  endfunction

  task automatic check_output(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed hi=%h lo=%h, expected hi=%h lo=%h",
             tag, obs[W:W-15], obs[63:0], exp[W:W-15], exp[63:0]);
    end
  endtask

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    in_a     = a;
    in_b     = b;
    subtract = sub;
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    checks   = 0;
    failures = 0;
    ones     = '1;

    resetn = 1'b0;
    apply_stimulus('0, '0, 1'b0);
    #2;
    check_output("reset_async", result, '0);
    tick();
    apply_stimulus(W'(5), W'(3), 1'b0);
    tick();
    check_output("reset_hold", result, '0);

    #2 resetn = 1'b1;
    tick();
    check_output("add_5_3", result, (W+1)'(8));
    apply_stimulus(W'(100), W'(1), 1'b0);
    #2;
    check_output("hold_until_edge", result, (W+1)'(8));

    apply_stimulus('0, W'(1), 1'b1);
    tick();
    check_output("sub_0_1", result, {(W+1){1'b1}});

    apply_stimulus(W'(5), W'(3), 1'b1);
    tick();
    check_output("sub_5_3", result, (W+1)'(2));

    apply_stimulus(ones, ones, 1'b0);
    tick();
    check_output("add_all_ones", result, {{W{1'b1}}, 1'b0});
    subtract = 1'b1;
    tick();
    check_output("sub_all_ones", result, '0);

    apply_stimulus('0, '0, 1'b0);
    tick();
    check_output("add_zero_zero", result, '0);
    apply_stimulus(W'(64'hDEAD_BEEF_1234_5678) << 500, W'(64'hDEAD_BEEF_1234_5678) << 500, 1'b1);
    tick();
    check_output("sub_equal", result, '0);

    for (int k = 64; k <= W; k += 64) begin
      int kk;
      kk = (k > 1024) ? W : k;
      apply_stimulus(W'(pow2(kk) - 1), W'(1), 1'b0);
      tick();
      check_output($sformatf("carry_k%0d", kk), result, pow2(kk));
      if (kk < W) begin
        apply_stimulus(W'(pow2(kk)), W'(1), 1'b1);
        tick();
        check_output($sformatf("borrow_k%0d", kk), result, pow2(kk) - 1);
      end
    end
    apply_stimulus(ones, W'(1), 1'b0);
    tick();
    check_output("carry_k1027", result, pow2(W));

    for (int i = 0; i < 24; i++) begin
      ra = rand_op();
      rb = (i % 4 == 1) ? ra ^ (W'(1) << (i * 37 % W)) : rand_op();
      rs = i[0];
      apply_stimulus(ra, rb, rs);
      tick();
      check_output($sformatf("rand_%0d", i), result, ref_model(ra, rb, rs));
      if (rs) begin
        check_output($sformatf("rand_sign_%0d", i), (W+1)'(result[W]), (W+1)'(ra < rb));
      end
    end

    apply_stimulus(W'(7), W'(9), 1'b0);
    tick();
    check_output("pre_reset_sum", result, (W+1)'(16));
    #2 resetn = 1'b0;
    #1;
    check_output("midstream_reset_async", result, '0);
    tick();
    check_output("midstream_reset_held", result, '0);
    #2 resetn = 1'b1;
    #1;
    check_output("release_before_edge", result, '0);
    tick();
    check_output("post_reset_sum", result, (W+1)'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
